// File: rtl/rx_asm.sv
// rx_asm: UART-style receiver, one bit per clock, no baud divider.
// Frame: start(0), DATA_WIDTH data bits LSB first, even parity, stop(1).
// Parity is either one bit after every byte (cumulative over the frame) or
// a single bit after the last data bit, selected by parity_per_byte.
// The result is presented on a valid/ready holding register.
// Optional feature: define RX_SYNC_EN to pass rx_in through a 2-flop
// synchronizer (reset to idle-high) before the FSM.
module rx_asm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  input  logic                  parity_per_byte,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  rx_busy
);

  localparam int BYTES   = (DATA_WIDTH / 8 > 0) ? DATA_WIDTH / 8 : 1;
  localparam int BIT_CW  = $clog2(DATA_WIDTH + 1);
  localparam int BYTE_CW = $clog2(BYTES + 1);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY_BYTE,
    PARITY_LAST,
    STOP
  } state_t;

  state_t                state;
  logic                  rx;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [BIT_CW-1:0]     bit_count;
  logic [BYTE_CW-1:0]    byte_count;
  logic                  parity;
  logic                  perr;
  logic                  ppb_lat;

`ifdef RX_SYNC_EN
  logic [1:0] sync;

  // Two-stage synchronizer; resets to the idle-high line level so no false start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx_in};
    end
  end

  assign rx = sync[1];
`else
  assign rx = rx_in;
`endif

  // Frame FSM plus the output holding register, all registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      data_reg    <= '0;
      bit_count   <= '0;
      byte_count  <= '0;
      parity      <= 1'b0;
      perr        <= 1'b0;
      ppb_lat     <= 1'b0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx) begin
            bit_count  <= '0;
            byte_count <= '0;
            parity     <= 1'b0;
            perr       <= 1'b0;
            ppb_lat    <= parity_per_byte;
            state      <= DATA;
            rx_busy    <= 1'b1;
          end
        end

        DATA: begin
          data_reg  <= {rx, data_reg[DATA_WIDTH-1:1]};
          parity    <= parity ^ rx;
          bit_count <= bit_count + BIT_CW'(1);
          if (ppb_lat && (32'(bit_count) == 7)) begin
            state <= PARITY_BYTE;
          end else if (!ppb_lat && (32'(bit_count) == DATA_WIDTH - 1)) begin
            state <= PARITY_LAST;
          end
        end

        PARITY_BYTE: begin
          perr       <= perr | (rx != parity);
          byte_count <= byte_count + BYTE_CW'(1);
          if (32'(byte_count) + 1 == BYTES) begin
            state <= STOP;
          end else begin
            bit_count <= '0;
            state     <= DATA;
          end
        end

        PARITY_LAST: begin
          perr  <= perr | (rx != parity);
          state <= STOP;
        end

        STOP: begin
          if (!valid_out || ready_in) begin
            data_out   <= data_reg;
            parity_err <= perr;
            frame_err  <= ~rx;
            valid_out  <= 1'b1;
          end else begin
            overrun_err <= 1'b1;
          end
          state   <= IDLE;
          rx_busy <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
